// File: rtl/ecyn_txrx_align.sv
// ecyn_txrx_align: delays the Tx reference I/Q stream by a programmable number
// of accepted samples relative to the Rx stream, feeding ecyn_top time-aligned
// Tx/Rx pairs. A fill/run FSM suppresses OutValid until the delay line holds
// D samples.
// Optional build macro: ECYN_ALIGN_CNT_EN adds a 32-bit aligned_cnt output
// that counts OutValid pulses.
module ecyn_txrx_align #(
   parameter int unsigned W         = 16,
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned DEF_DELAY = 0
) (
   input  logic                         clk,
   input  logic                         rn,
   input  logic                         en,
   input  logic                         InValid,
   input  logic signed [W-1:0]          TxIn_I_,
   input  logic signed [W-1:0]          TxIn_Q_,
   input  logic signed [W-1:0]          RxIn_I_,
   input  logic signed [W-1:0]          RxIn_Q_,
   input  logic                         cfg_load,
   input  logic [$clog2(DEPTH):0]       cfg_delay,
   output logic                         OutValid,
   output logic signed [W-1:0]          TxOut_I_,
   output logic signed [W-1:0]          TxOut_Q_,
   output logic signed [W-1:0]          RxOut_I_,
   output logic signed [W-1:0]          RxOut_Q_,
   output logic                         primed,
`ifdef ECYN_ALIGN_CNT_EN
   output logic                         cfg_err,
   output logic [31:0]                  aligned_cnt
`else
   output logic                         cfg_err
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef struct packed {
      logic [W-1:0] i;
      logic [W-1:0] q;
   } iq_t;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam state_t RST_STATE = (DEF_DELAY == 0) ? RUN : FILL;

   // Tx delay line; contents are never cleared, only overwritten
   iq_t             r_mem [DEPTH];

   state_t          r_state;
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_fill;
   logic [AW-1:0]   r_delay;
   logic            r_cfg_err;
   logic            r_out_vld;
   logic            r_primed;
   iq_t             r_tx;
   iq_t             r_rx;

   logic            w_acc;
   logic [AW-1:0]   w_raddr;
   iq_t             w_tx_in;
   iq_t             w_tx_dly;
   state_t          w_state_nxt;
   logic [AW-1:0]   w_fill_nxt;
   logic [AW-1:0]   w_delay_nxt;
   logic            w_err_nxt;
   logic            w_vld_nxt;

   assign w_acc    = InValid & en;
   assign w_tx_in  = '{i: TxIn_I_, q: TxIn_Q_};
   assign w_raddr  = r_wptr - r_delay;
   // D == 0 bypasses the buffer so the current Tx sample passes straight through
   assign w_tx_dly = (r_delay == '0) ? w_tx_in : r_mem[w_raddr];

   // Next-state: config load, fill counting and output-valid generation
   always_comb begin
      w_state_nxt = r_state;
      w_fill_nxt  = r_fill;
      w_delay_nxt = r_delay;
      w_err_nxt   = r_cfg_err;
      w_vld_nxt   = 1'b0;
      if (cfg_load) begin
         if (cfg_delay[AW]) begin
            w_delay_nxt = AW'(DEPTH - 1);
            w_err_nxt   = 1'b1;
         end else begin
            w_delay_nxt = cfg_delay[AW-1:0];
         end
         // a sample accepted alongside the load is fill sample 0 of the new config
         w_fill_nxt  = (w_acc && (w_delay_nxt != '0)) ? AW'(1) : '0;
         w_state_nxt = (w_delay_nxt == '0) ? RUN : FILL;
      end else if (w_acc) begin
         case (r_state)
            FILL: begin
               if (r_fill == r_delay) begin
                  w_vld_nxt   = 1'b1;
                  w_state_nxt = RUN;
               end else begin
                  w_fill_nxt  = r_fill + AW'(1);
               end
            end
            RUN:     w_vld_nxt   = 1'b1;
            default: w_state_nxt = FILL;
         endcase
      end
   end

   // Control state and registered outputs
   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         r_state   <= RST_STATE;
         r_wptr    <= '0;
         r_fill    <= '0;
         r_delay   <= AW'(DEF_DELAY);
         r_cfg_err <= 1'b0;
         r_out_vld <= 1'b0;
         r_primed  <= (RST_STATE == RUN);
         r_tx      <= '0;
         r_rx      <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_fill    <= w_fill_nxt;
         r_delay   <= w_delay_nxt;
         r_cfg_err <= w_err_nxt;
         r_out_vld <= w_vld_nxt;
         r_primed  <= (w_state_nxt == RUN);
         if (w_acc) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_vld_nxt) begin
            r_tx <= w_tx_dly;
            r_rx <= '{i: RxIn_I_, q: RxIn_Q_};
         end
      end
   end

   // Delay-line write port
   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_mem[r_wptr] <= w_tx_in;
      end
   end

`ifdef ECYN_ALIGN_CNT_EN
   logic [31:0] r_cnt;

   // OutValid pulse counter, restarted by each config load
   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         r_cnt <= '0;
      end else if (cfg_load) begin
         r_cnt <= '0;
      end else if (w_vld_nxt) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign aligned_cnt = r_cnt;
`endif

   assign OutValid = r_out_vld;
   assign TxOut_I_ = r_tx.i;
   assign TxOut_Q_ = r_tx.q;
   assign RxOut_I_ = r_rx.i;
   assign RxOut_Q_ = r_rx.q;
   assign primed   = r_primed;
   assign cfg_err  = r_cfg_err;

endmodule
